reg_view_selector: RTL and testbench

Front-end stage of the register viewer: owns the two push-buttons that step through the MIPS register file and captures the selected register's contents. Drives the register file's debug read port and presents a stable 32-bit value to the 4-digit decimal display stage, which consumes `reg_data` directly. Periodically re-samples the register so the display tracks the running program.

---
 rtl/reg_view_pkg.sv | 32 +++
 rtl/key_debounce.sv | 54 +++++
 rtl/reg_view_selector.sv | 140 ++++++++++++++
 tb/tb_reg_view_selector.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_view_pkg.sv
// Shared types and constants for the register viewer front-end.
package reg_view_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] LAST_REG = REG_ADDR_W'(NUM_REGS - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    SAMPLE = 1'b1
  } view_state_t;

  // Step the register index by one key event, wrapping around the register file.
  // Opposing events cancel so that a simultaneous next+prev leaves the index alone.
  function automatic logic [REG_ADDR_W-1:0] step_index(
    input logic [REG_ADDR_W-1:0] idx,
    input logic                  go_next,
    input logic                  go_prev
  );
    logic [REG_ADDR_W-1:0] res;
    res = idx;
    if (go_next && !go_prev) begin
      res = (idx == LAST_REG) ? '0 : idx + REG_ADDR_W'(1);
    end else if (go_prev && !go_next) begin
      res = (idx == '0) ? LAST_REG : idx - REG_ADDR_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability counter and a
// one-cycle press pulse on each accepted released-to-pressed transition.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             key_sync_p0;
  logic             key_sync_p1;
  logic             level;
  logic [CNT_W-1:0] stable_cnt;

  // Bring the raw key into the clock domain; idle level is released (1).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_sync_p0 <= 1'b1;
      key_sync_p1 <= 1'b1;
    end else begin
      key_sync_p0 <= key_n;
      key_sync_p1 <= key_sync_p0;
    end
  end

  // Accept a new level only after it has persisted; any bounce back restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level      <= 1'b1;
      stable_cnt <= '0;
      press      <= 1'b0;
    end else begin
      press <= 1'b0;
      if (key_sync_p1 != level) begin
        if (stable_cnt == CNT_LAST) begin
          level      <= key_sync_p1;
          stable_cnt <= '0;
          // Only the falling (pressed) edge is an event; release is silent.
          press      <= ~key_sync_p1;
        end else begin
          stable_cnt <= stable_cnt + CNT_W'(1);
        end
      end else begin
        stable_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/reg_view_selector.sv
// Register viewer front-end: turns the next/prev keys into a register index,
// drives the register-file debug port and captures the selected value, with a
// periodic re-sample so the display follows the running program.
module reg_view_selector
  import reg_view_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REFRESH_CYCLES  = 5000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_next_n,
  input  logic        key_prev_n,
  output logic [4:0]  rf_rd_addr,
  input  logic [31:0] rf_rd_data,
  output logic [31:0] reg_data,
  output logic [4:0]  reg_index,
  output logic        valid
);

  localparam int RF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [RF_W-1:0] REFRESH_LAST = RF_W'(REFRESH_CYCLES - 1);

  logic            press_next;
  logic            press_prev;
  logic            pend_next;
  logic            pend_prev;
  view_state_t     state;
  view_state_t     state_nxt;
  logic            consume;
  logic            capture;
  logic [RF_W-1:0] refresh_cnt;
  logic            refresh_done;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_next (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_next_n),
    .press (press_next)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_prev (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_prev_n),
    .press (press_prev)
  );

  assign refresh_done = (refresh_cnt == REFRESH_LAST);

  // Hold each press until the FSM consumes it; a fresh press outranks a clear so none is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_next <= 1'b0;
      pend_prev <= 1'b0;
    end else begin
      if (press_next) begin
        pend_next <= 1'b1;
      end else if (consume) begin
        pend_next <= 1'b0;
      end
      if (press_prev) begin
        pend_prev <= 1'b1;
      end else if (consume) begin
        pend_prev <= 1'b0;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control: key events win over the periodic refresh.
  always_comb begin
    state_nxt = state;
    consume   = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (pend_next || pend_prev) begin
          consume   = 1'b1;
          state_nxt = SAMPLE;
        end else if (refresh_done) begin
          state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        capture   = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Count idle cycles up to the refresh point and hold there until a sample clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt <= '0;
    end else if (capture) begin
      refresh_cnt <= '0;
    end else if ((state == IDLE) && !refresh_done) begin
      refresh_cnt <= refresh_cnt + RF_W'(1);
    end
  end

  // Read address moves one cycle ahead of the capture so the register file has a full period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_rd_addr <= '0;
    end else if (consume) begin
      rf_rd_addr <= step_index(rf_rd_addr, pend_next, pend_prev);
    end
  end

  // Capture the register contents and the index they belong to as one consistent pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_data  <= '0;
      reg_index <= '0;
      valid     <= 1'b0;
    end else if (capture) begin
      reg_data  <= rf_rd_data;
      reg_index <= rf_rd_addr;
      valid     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_view_selector.sv
// Directed bench for reg_view_selector with short debounce/refresh intervals.
module tb_reg_view_selector;

  localparam int DEB = 4;
  localparam int REF = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_next_n = 1'b1;
  logic        key_prev_n = 1'b1;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic [31:0] reg_data;
  logic [4:0]  reg_index;
  logic        valid;
  logic [31:0] rf_bias = 32'd0;

  int checks = 0;
  int errors = 0;

  reg_view_selector #(
    .DEBOUNCE_CYCLES(DEB),
    .REFRESH_CYCLES (REF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_next_n (key_next_n),
    .key_prev_n (key_prev_n),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data),
    .reg_data   (reg_data),
    .reg_index  (reg_index),
    .valid      (valid)
  );

  always #5 clk = ~clk;

  // Register-file model: contents are addr*3, plus an offset standing in for program writes.
  assign rf_rd_data = 32'(rf_rd_addr) * 32'd3 + rf_bias;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench just after edge "0"; the next posedge is cycle 1.
  task automatic do_reset;
    rst = 1'b1;
    key_next_n = 1'b1;
    key_prev_n = 1'b1;
    rf_bias = 32'd0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic press(input bit nxt, input bit prv);
    if (nxt) key_next_n = 1'b0;
    if (prv) key_prev_n = 1'b0;
    tick(8);
    key_next_n = 1'b1;
    key_prev_n = 1'b1;
    tick(10);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    key_next_n = 1'b1;
    key_prev_n = 1'b1;
    rf_bias = 32'd0;
    tick(2);
    checks++; if (rf_rd_addr !== 5'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", rf_rd_addr); end
    checks++; if (reg_index !== 5'd0) begin errors++; $display("FAIL reset_index got %0d want 0", reg_index); end
    checks++; if (reg_data !== 32'd0) begin errors++; $display("FAIL reset_data got %0d want 0", reg_data); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", valid); end
    rst = 1'b0;
    tick(16);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL refresh_valid_c16 got %0b want 0", valid); end
    tick(1);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL refresh_valid_c17 got %0b want 1", valid); end
    checks++; if (reg_index !== 5'd0) begin errors++; $display("FAIL refresh_index_c17 got %0d want 0", reg_index); end
    checks++; if (reg_data !== 32'd0) begin errors++; $display("FAIL refresh_data_c17 got %0d want 0", reg_data); end
    rf_bias = 32'd100;
    tick(16);
    checks++; if (reg_data !== 32'd0) begin errors++; $display("FAIL refresh_data_c33 got %0d want 0", reg_data); end
    tick(1);
    checks++; if (reg_data !== 32'd100) begin errors++; $display("FAIL refresh_data_c34 got %0d want 100", reg_data); end
    rf_bias = 32'd0;
    tick(16);
    checks++; if (reg_data !== 32'd100) begin errors++; $display("FAIL refresh_data_c50 got %0d want 100", reg_data); end
    tick(1);
    checks++; if (reg_data !== 32'd0) begin errors++; $display("FAIL refresh_data_c51 got %0d want 0", reg_data); end
  endtask

  task automatic test_clean_next;
    do_reset();
    key_next_n = 1'b0;
    tick(7);
    checks++; if (rf_rd_addr !== 5'd0) begin errors++; $display("FAIL clean_addr_t7 got %0d want 0", rf_rd_addr); end
    tick(1);
    checks++; if (rf_rd_addr !== 5'd1) begin errors++; $display("FAIL clean_addr_t8 got %0d want 1", rf_rd_addr); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL clean_valid_t8 got %0b want 0", valid); end
    tick(1);
    checks++; if (reg_index !== 5'd1) begin errors++; $display("FAIL clean_index_t9 got %0d want 1", reg_index); end
    checks++; if (reg_data !== 32'd3) begin errors++; $display("FAIL clean_data_t9 got %0d want 3", reg_data); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL clean_valid_t9 got %0b want 1", valid); end
    key_next_n = 1'b1;
    tick(30);
    checks++; if (rf_rd_addr !== 5'd1) begin errors++; $display("FAIL clean_release_addr got %0d want 1", rf_rd_addr); end
  endtask

  task automatic test_bouncy;
    do_reset();
    key_next_n = 1'b0;
    tick(3);
    key_next_n = 1'b1;
    tick(1);
    key_next_n = 1'b0;
    tick(6);
    tick(1);
    checks++; if (rf_rd_addr !== 5'd0) begin errors++; $display("FAIL bouncy_addr_c11 got %0d want 0", rf_rd_addr); end
    tick(1);
    checks++; if (rf_rd_addr !== 5'd1) begin errors++; $display("FAIL bouncy_addr_c12 got %0d want 1", rf_rd_addr); end
    tick(1);
    checks++; if (reg_index !== 5'd1) begin errors++; $display("FAIL bouncy_index_c13 got %0d want 1", reg_index); end
    checks++; if (reg_data !== 32'd3) begin errors++; $display("FAIL bouncy_data_c13 got %0d want 3", reg_data); end
    tick(1);
    key_next_n = 1'b1;
    tick(2);
    key_next_n = 1'b0;
    tick(1);
    key_next_n = 1'b1;
    tick(40);
    checks++; if (rf_rd_addr !== 5'd1) begin errors++; $display("FAIL bouncy_release_addr got %0d want 1", rf_rd_addr); end
    checks++; if (reg_index !== 5'd1) begin errors++; $display("FAIL bouncy_release_index got %0d want 1", reg_index); end
  endtask

  task automatic test_wrap;
    do_reset();
    press(1'b0, 1'b1);
    checks++; if (rf_rd_addr !== 5'd31) begin errors++; $display("FAIL wrap_prev0_addr got %0d want 31", rf_rd_addr); end
    checks++; if (reg_index !== 5'd31) begin errors++; $display("FAIL wrap_prev0_index got %0d want 31", reg_index); end
    press(1'b1, 1'b0);
    checks++; if (reg_index !== 5'd0) begin errors++; $display("FAIL wrap_next31_index got %0d want 0", reg_index); end
    checks++; if (reg_data !== 32'd0) begin errors++; $display("FAIL wrap_next31_data got %0d want 0", reg_data); end
    press(1'b0, 1'b1);
    checks++; if (reg_index !== 5'd31) begin errors++; $display("FAIL wrap_prev_index got %0d want 31", reg_index); end
    checks++; if (reg_data !== 32'd93) begin errors++; $display("FAIL wrap_prev_data got %0d want 93", reg_data); end
  endtask

  task automatic test_simultaneous;
    do_reset();
    key_next_n = 1'b0;
    key_prev_n = 1'b0;
    tick(8);
    checks++; if (rf_rd_addr !== 5'd0) begin errors++; $display("FAIL simul_addr_t8 got %0d want 0", rf_rd_addr); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL simul_valid_t8 got %0b want 0", valid); end
    tick(1);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL simul_sample_t9 got %0b want 1", valid); end
    checks++; if (reg_index !== 5'd0) begin errors++; $display("FAIL simul_index_t9 got %0d want 0", reg_index); end
    key_next_n = 1'b1;
    key_prev_n = 1'b1;
    tick(20);
    checks++; if (rf_rd_addr !== 5'd0) begin errors++; $display("FAIL simul_addr_end got %0d want 0", rf_rd_addr); end
  endtask

  task automatic test_press_during_sample;
    do_reset();
    tick(9);
    key_next_n = 1'b0;
    tick(8);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL held_refresh_valid_c17 got %0b want 1", valid); end
    checks++; if (reg_index !== 5'd0) begin errors++; $display("FAIL held_refresh_index_c17 got %0d want 0", reg_index); end
    checks++; if (rf_rd_addr !== 5'd0) begin errors++; $display("FAIL held_addr_c17 got %0d want 0", rf_rd_addr); end
    tick(1);
    checks++; if (rf_rd_addr !== 5'd1) begin errors++; $display("FAIL held_addr_c18 got %0d want 1", rf_rd_addr); end
    tick(1);
    checks++; if (reg_index !== 5'd1) begin errors++; $display("FAIL held_index_c19 got %0d want 1", reg_index); end
    checks++; if (reg_data !== 32'd3) begin errors++; $display("FAIL held_data_c19 got %0d want 3", reg_data); end
    key_next_n = 1'b1;
    tick(10);
  endtask

  task automatic test_reset_in_sample;
    bit found;
    do_reset();
    for (int k = 0; k < 4; k++) press(1'b1, 1'b0);
    checks++; if (rf_rd_addr !== 5'd4) begin errors++; $display("FAIL rsamp_setup_addr got %0d want 4", rf_rd_addr); end
    key_next_n = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick(1);
      if (rf_rd_addr == 5'd5) found = 1'b1;
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL rsamp_wait_addr5 got %0d want 5", rf_rd_addr); end
    key_next_n = 1'b1;
    rst = 1'b1;
    tick(1);
    checks++; if (rf_rd_addr !== 5'd0) begin errors++; $display("FAIL rsamp_addr got %0d want 0", rf_rd_addr); end
    checks++; if (reg_index !== 5'd0) begin errors++; $display("FAIL rsamp_index got %0d want 0", reg_index); end
    checks++; if (reg_data !== 32'd0) begin errors++; $display("FAIL rsamp_data got %0d want 0", reg_data); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rsamp_valid got %0b want 0", valid); end
    rst = 1'b0;
    key_next_n = 1'b0;
    tick(8);
    checks++; if (rf_rd_addr !== 5'd1) begin errors++; $display("FAIL rsamp_after_addr got %0d want 1", rf_rd_addr); end
    tick(1);
    checks++; if (reg_index !== 5'd1) begin errors++; $display("FAIL rsamp_after_index got %0d want 1", reg_index); end
    checks++; if (reg_data !== 32'd3) begin errors++; $display("FAIL rsamp_after_data got %0d want 3", reg_data); end
    key_next_n = 1'b1;
    tick(10);
  endtask

  initial begin
    test_reset();
    test_clean_next();
    test_bouncy();
    test_wrap();
    test_simultaneous();
    test_press_during_sample();
    test_reset_in_sample();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
